// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue stage: sizes, RS unit codes and state/kind enums.
// Also provides the helper that sorts an opcode into issue / halt / nop.
package issue_unit_pkg;

    localparam int REG_SIZE   = 5;
    localparam int WORD_SIZE  = 32;
    localparam int UNIT_SIZE  = 3;
    localparam int INSTR_SIZE = 32;
    localparam int IMM_SIZE   = 13;

    localparam logic [UNIT_SIZE-1:0] LW   = 3'b000;
    localparam logic [UNIT_SIZE-1:0] SW   = 3'b001;
    localparam logic [UNIT_SIZE-1:0] ADD  = 3'b010;
    localparam logic [UNIT_SIZE-1:0] MUL  = 3'b011;
    localparam logic [UNIT_SIZE-1:0] MV   = 3'b100;
    localparam logic [UNIT_SIZE-1:0] HALT = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HALT} issue_state_t;
    typedef enum logic [1:0] {KIND_ISSUE, KIND_HALT, KIND_NOP} code_kind_t;

    // Codes above MV other than HALT carry no work and are silently dropped.
    function automatic code_kind_t classify(input logic [UNIT_SIZE-1:0] code);
        case (code)
            LW, SW, ADD, MUL, MV: return KIND_ISSUE;
            HALT:                 return KIND_HALT;
            default:              return KIND_NOP;
        endcase
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Two-entry instruction buffer; exposes both the head and the entry behind it
// so the issue FSM can line up the next request while the head is being accepted.
module issue_fifo
    import issue_unit_pkg::*;
#(
    parameter int WIDTH = INSTR_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second,
    output logic [1:0]       count
);

    // Entries shift toward head on pop; a push lands in the first free slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head   <= '0;
            second <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               second <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= second;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head   <= second;
                        second <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Issue stage: buffers fetched instructions, decodes the head and hands it to the
// reservation stations with a registered enable/ack handshake; halts on code 101.
module issue_unit #(
    parameter int REG_SIZE  = issue_unit_pkg::REG_SIZE,
    parameter int WORD_SIZE = issue_unit_pkg::WORD_SIZE,
    parameter int CNT_SIZE  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 instr_valid,
    input  logic [31:0]                          instr,
    output logic                                 instr_ready,
    output logic [issue_unit_pkg::UNIT_SIZE-1:0] unit,
    output logic [REG_SIZE-1:0]                  reg1,
    output logic [REG_SIZE-1:0]                  reg2,
    output logic [REG_SIZE-1:0]                  reg3,
    output logic                                 hasimm,
    output logic [WORD_SIZE-1:0]                 imm,
    output logic                                 enable,
    input  logic                                 rs_out,
    output logic                                 halted,
    output logic [CNT_SIZE-1:0]                  issued_count
);
    import issue_unit_pkg::*;

    issue_state_t         state;
    logic [1:0]           fifo_count;
    logic [31:0]          fifo_head;
    logic [31:0]          fifo_second;
    logic                 xfer;
    logic                 accept;
    logic                 idle_take;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 cand_valid;
    logic [31:0]          cand_word;
    code_kind_t           cand_kind;
    logic [UNIT_SIZE-1:0] dec_unit;
    logic [REG_SIZE-1:0]  dec_reg1;
    logic [REG_SIZE-1:0]  dec_reg2;
    logic [REG_SIZE-1:0]  dec_reg3;
    logic                 dec_hasimm;
    logic [WORD_SIZE-1:0] dec_imm;

    assign instr_ready = !rst && (fifo_count != 2'd2) && !halted;
    assign xfer        = instr_valid && instr_ready;
    assign accept      = (state == ST_REQ) && rs_out;
    assign idle_take   = (state == ST_IDLE) && cand_valid;

    // The candidate is the instruction that becomes the head after this edge;
    // taking it straight from instr when the buffer would otherwise be empty
    // gives single-cycle latency and back-to-back issue.
    always_comb begin
        cand_valid = 1'b0;
        cand_word  = fifo_head;
        case (state)
            ST_IDLE: begin
                if (fifo_count != 2'd0) begin
                    cand_valid = 1'b1;
                end else if (xfer) begin
                    cand_valid = 1'b1;
                    cand_word  = instr;
                end
            end
            ST_REQ: begin
                if (fifo_count == 2'd2) begin
                    cand_valid = 1'b1;
                    cand_word  = fifo_second;
                end else if (xfer) begin
                    cand_valid = 1'b1;
                    cand_word  = instr;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cand_kind  = classify(cand_word[31:29]);
        dec_unit   = cand_word[31:29];
        dec_reg1   = REG_SIZE'(cand_word[28:24]);
        dec_reg2   = REG_SIZE'(cand_word[23:19]);
        dec_reg3   = REG_SIZE'(cand_word[18:14]);
        dec_hasimm = cand_word[13];
        dec_imm    = {{(WORD_SIZE-IMM_SIZE){cand_word[IMM_SIZE-1]}}, cand_word[IMM_SIZE-1:0]};
    end

    // A nop arriving into an empty idle buffer is simply never stored.
    assign fifo_push  = xfer && !(idle_take && fifo_count == 2'd0 && cand_kind == KIND_NOP);
    assign fifo_pop   = accept || (idle_take && cand_kind == KIND_NOP && fifo_count != 2'd0);
    assign fifo_flush = (idle_take || (accept && cand_valid)) && cand_kind == KIND_HALT;

    issue_fifo #(.WIDTH(32)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (fifo_flush),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (instr),
        .head   (fifo_head),
        .second (fifo_second),
        .count  (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            unit         <= '0;
            reg1         <= '0;
            reg2         <= '0;
            reg3         <= '0;
            hasimm       <= 1'b0;
            imm          <= '0;
            enable       <= 1'b0;
            halted       <= 1'b0;
            issued_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand_valid && cand_kind == KIND_ISSUE) begin
                        state  <= ST_REQ;
                        enable <= 1'b1;
                        unit   <= dec_unit;
                        reg1   <= dec_reg1;
                        reg2   <= dec_reg2;
                        reg3   <= dec_reg3;
                        hasimm <= dec_hasimm;
                        imm    <= dec_imm;
                    end else if (cand_valid && cand_kind == KIND_HALT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rs_out) begin
                        issued_count <= issued_count + CNT_SIZE'(1);
                        if (cand_valid && cand_kind == KIND_ISSUE) begin
                            unit   <= dec_unit;
                            reg1   <= dec_reg1;
                            reg2   <= dec_reg2;
                            reg3   <= dec_reg3;
                            hasimm <= dec_hasimm;
                            imm    <= dec_imm;
                        end else if (cand_valid && cand_kind == KIND_HALT) begin
                            state  <= ST_HALT;
                            enable <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            enable <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: directed handshake scenarios plus a random run
// checked against an in-order model of which accepted instructions must reach the RS.
module tb_issue_unit;

    localparam int TB_CNT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic [31:0]       instr = '0;
    logic              rs_out = 1'b0;
    logic              instr_ready;
    logic [2:0]        unit;
    logic [4:0]        reg1, reg2, reg3;
    logic              hasimm;
    logic [31:0]       imm;
    logic              enable;
    logic              halted;
    logic [TB_CNT-1:0] issued_count;
    logic [50:0]       dut_fields;

    int          tests_run = 0;
    int          fail_count = 0;
    logic [50:0] exp_q[$];
    bit          model_halted = 0;
    int          model_issued = 0;
    bit          prev_pending = 0;
    logic [50:0] prev_fields = '0;
    bit          rs_random = 0;

    issue_unit #(.REG_SIZE(5), .WORD_SIZE(32), .CNT_SIZE(TB_CNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .unit         (unit),
        .reg1         (reg1),
        .reg2         (reg2),
        .reg3         (reg3),
        .hasimm       (hasimm),
        .imm          (imm),
        .enable       (enable),
        .rs_out       (rs_out),
        .halted       (halted),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    assign dut_fields = {unit, reg1, reg2, reg3, hasimm, imm};

    function automatic logic [31:0] makeInstr(input logic [2:0] u, input logic [4:0] a,
                                              input logic [4:0] b, input logic [4:0] c,
                                              input logic h, input logic [12:0] i);
        return {u, a, b, c, h, i};
    endfunction

    // What the RS must see for an instruction word: fields copied, imm as a signed number.
    function automatic logic [50:0] expectedFields(input logic [31:0] w);
        int v;
        v = int'(w[12:0]);
        if (v >= 4096) v = v - 8192;
        return {w[31:29], w[28:24], w[23:19], w[18:14], w[13], 32'(v)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests_run++;
        if (actual !== required) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        bit accepted = 0;
        int waited = 0;
        instr = word;
        instr_valid = 1'b1;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            accepted = instr_ready;
            tick();
            waited++;
        end
        instr_valid = 1'b0;
        if (!accepted) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL accept_timeout: got no acceptance of %0h, required acceptance", word);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rs_random) rs_out = 1'($urandom_range(0, 1));
    end

    // Monitor: tracks acceptances into the model and checks every RS handshake.
    always @(negedge clk) begin
        logic [50:0] want;
        if (rst) begin
            exp_q.delete();
            model_halted = 0;
            model_issued = 0;
            prev_pending = 0;
        end else begin
            if (prev_pending) begin
                checkOutput("held_enable", 64'(enable), 64'(1));
                checkOutput("held_fields", 64'(dut_fields), 64'(prev_fields));
            end
            if (enable && rs_out) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_issue: got unit %0d, required no issue", unit);
                end else begin
                    want = exp_q.pop_front();
                    checkOutput("issue_fields", 64'(dut_fields), 64'(want));
                end
                checkOutput("issue_count", 64'(issued_count), 64'(model_issued % (1 << TB_CNT)));
                model_issued++;
            end
            if (instr_valid && instr_ready && !model_halted) begin
                if (instr[31:29] == 3'b101) model_halted = 1;
                else if (instr[31:29] <= 3'b100) exp_q.push_back(expectedFields(instr));
            end
            prev_pending = enable && !rs_out;
            prev_fields = dut_fields;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] units[3];
        bit accepted;
        int waited;
        int r;
        logic [2:0] u;

        // Reset state
        tick();
        tick();
        checkOutput("reset_fields", 64'(dut_fields), 64'(0));
        checkOutput("reset_enable", 64'(enable), 64'(0));
        checkOutput("reset_halted", 64'(halted), 64'(0));
        checkOutput("reset_count", 64'(issued_count), 64'(0));
        checkOutput("reset_ready", 64'(instr_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 64'(instr_ready), 64'(1));

        // Single add with rs_out tied high
        rs_out = 1'b1;
        applyStimulus(makeInstr(3'b010, 5'd1, 5'd2, 5'd3, 1'b0, 13'd0));
        checkOutput("add_enable", 64'(enable), 64'(1));
        checkOutput("add_unit", 64'(unit), 64'(2));
        checkOutput("add_regs", 64'({reg1, reg2, reg3}), 64'({5'd1, 5'd2, 5'd3}));
        tick();
        checkOutput("add_enable_drop", 64'(enable), 64'(0));
        checkOutput("add_count", 64'(issued_count), 64'(1));

        // lw with negative imm, RS stalls for 5 cycles
        rs_out = 1'b0;
        applyStimulus(makeInstr(3'b000, 5'd4, 5'd5, 5'd6, 1'b1, 13'h1FFF));
        checkOutput("lw_imm", 64'(imm), 64'(32'hFFFF_FFFF));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("lw_stall_enable", 64'(enable), 64'(1));
            checkOutput("lw_stall_count", 64'(issued_count), 64'(1));
        end
        rs_out = 1'b1;
        tick();
        rs_out = 1'b0;
        checkOutput("lw_count", 64'(issued_count), 64'(2));
        checkOutput("lw_enable_drop", 64'(enable), 64'(0));

        // Three back-to-back pushes against a stalled RS, then drain without gaps
        units[0] = 3'b001;
        units[1] = 3'b011;
        units[2] = 3'b100;
        applyStimulus(makeInstr(units[0], 5'd7, 5'd8, 5'd9, 1'b0, 13'd5));
        applyStimulus(makeInstr(units[1], 5'd10, 5'd11, 5'd12, 1'b1, 13'd100));
        @(negedge clk);
        checkOutput("ready_full", 64'(instr_ready), 64'(0));
        tick();
        instr = makeInstr(units[2], 5'd13, 5'd14, 5'd15, 1'b0, 13'h1000);
        instr_valid = 1'b1;
        rs_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("b2b_enable", 64'(enable), 64'(1));
            checkOutput("b2b_unit", 64'(unit), 64'(units[i]));
            accepted = instr_valid && instr_ready;
            tick();
            if (accepted) instr_valid = 1'b0;
        end
        rs_out = 1'b0;
        checkOutput("b2b_count", 64'(issued_count), 64'(5));
        checkOutput("b2b_enable_drop", 64'(enable), 64'(0));

        // mv, halt, add
        doReset();
        rs_out = 1'b1;
        applyStimulus(makeInstr(3'b100, 5'd1, 5'd0, 5'd0, 1'b0, 13'd0));
        applyStimulus(makeInstr(3'b101, 5'd0, 5'd0, 5'd0, 1'b0, 13'd0));
        instr = makeInstr(3'b010, 5'd2, 5'd3, 5'd4, 1'b0, 13'd0);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("halt_ready", 64'(instr_ready), 64'(0));
            tick();
        end
        instr_valid = 1'b0;
        checkOutput("halt_halted", 64'(halted), 64'(1));
        checkOutput("halt_enable", 64'(enable), 64'(0));
        checkOutput("halt_count", 64'(issued_count), 64'(1));

        // Reset while a request is pending
        doReset();
        checkOutput("halted_cleared", 64'(halted), 64'(0));
        rs_out = 1'b0;
        applyStimulus(makeInstr(3'b010, 5'd3, 5'd3, 5'd3, 1'b0, 13'd0));
        checkOutput("midrst_enable_before", 64'(enable), 64'(1));
        rst = 1'b1;
        tick();
        checkOutput("midrst_enable", 64'(enable), 64'(0));
        checkOutput("midrst_count", 64'(issued_count), 64'(0));
        checkOutput("midrst_ready", 64'(instr_ready), 64'(0));
        rst = 1'b0;
        rs_out = 1'b1;
        #1;
        checkOutput("midrst_ready_after", 64'(instr_ready), 64'(1));
        tick();
        tick();
        checkOutput("midrst_empty", 64'(enable), 64'(0));
        rs_out = 1'b0;

        // Random run; narrow counter makes issued_count wrap several times
        doReset();
        rs_random = 1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            r = int'($urandom_range(0, 9));
            if (r <= 7) u = 3'(r % 5);
            else if (r == 8) u = 3'b110;
            else u = 3'b111;
            applyStimulus(makeInstr(u, 5'($urandom), 5'($urandom), 5'($urandom),
                                    1'($urandom), 13'($urandom)));
        end
        waited = 0;
        while ((exp_q.size() != 0 || enable) && waited < 300) begin
            tick();
            waited++;
        end
        rs_random = 0;
        tick();
        rs_out = 1'b0;
        checkOutput("drain_pending", 64'(exp_q.size()), 64'(0));
        checkOutput("final_count", 64'(issued_count), 64'(model_issued % (1 << TB_CNT)));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
